// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus responder: address map, status bit
// positions and the region-select type produced by the address decoder.
package dbus_pkg;

  localparam logic [31:0] ADDR_OUT_DATA   = 32'h0000_8000;
  localparam logic [31:0] ADDR_OUT_STATUS = 32'h0000_8004;
  localparam logic [31:0] ADDR_TIMER      = 32'h0000_8008;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_CNT_LO = 3;
  localparam int STAT_CNT_HI = 7;

  typedef enum logic [2:0] {
    REG_RAM        = 3'd0,
    REG_OUT_DATA   = 3'd1,
    REG_OUT_STATUS = 3'd2,
    REG_TIMER      = 3'd3,
    REG_NONE       = 3'd4
  } region_e;

  // Byte address with the sub-word offset discarded.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with power-of-two depth; a push is accepted when not full or when
// a pop happens in the same cycle, so a full FIFO can stream at full rate.
module byte_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   din,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic [7:0]                   head
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push_s && !reset) mem_r[wr_ptr_r] <= din;
  end

  assign full  = (count_r == CW'(FIFO_DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/dbus_responder.sv
// CPU data-bus responder: word RAM, byte output FIFO with status register and,
// when DBUS_TIMER_EN is defined, a free-running loadable 32-bit timer.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram_r [RAM_WORDS];
  logic [31:0]   waddr_s;
  region_e       region_s;
  logic          we_s;
  logic          push_s;
  logic          pop_s;
  logic          status_wr_s;
  logic          ovf_event_s;
  logic          ovf_r;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [7:0]    fifo_head_s;
  logic [31:0]   status_s;

  assign waddr_s = word_addr(addr);

  // Address decode into a single region select.
  always_comb begin
    region_s = REG_NONE;
    if (waddr_s[31:AW+2] == {(30-AW){1'b0}}) region_s = REG_RAM;
    else if (waddr_s == ADDR_OUT_DATA)       region_s = REG_OUT_DATA;
    else if (waddr_s == ADDR_OUT_STATUS)     region_s = REG_OUT_STATUS;
`ifdef DBUS_TIMER_EN
    else if (waddr_s == ADDR_TIMER)          region_s = REG_TIMER;
`endif
    else                                     region_s = REG_NONE;
  end

  assign we_s        = memwrite && !reset;
  assign push_s      = we_s && (region_s == REG_OUT_DATA);
  assign status_wr_s = we_s && (region_s == REG_OUT_STATUS);
  assign pop_s       = !fifo_empty_s && out_ready;
  assign ovf_event_s = push_s && fifo_full_s && !pop_s;

  byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (writedata[7:0]),
    .pop   (pop_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s),
    .head  (fifo_head_s)
  );

  // Data RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_s && (region_s == REG_RAM)) ram_r[addr[AW+1:2]] <= writedata;
  end

  // Sticky overflow: a dropped byte outranks a clearing status write.
  always_ff @(posedge clk) begin
    if (reset)            ovf_r <= 1'b0;
    else if (ovf_event_s) ovf_r <= 1'b1;
    else if (status_wr_s) ovf_r <= 1'b0;
    else                  ovf_r <= ovf_r;
  end

`ifdef DBUS_TIMER_EN
  logic [31:0] timer_r;

  // Free-running timer; a CPU write replaces this cycle's increment.
  always_ff @(posedge clk) begin
    if (reset)                              timer_r <= 32'h0000_0000;
    else if (we_s && region_s == REG_TIMER) timer_r <= writedata;
    else                                    timer_r <= timer_r + 32'd1;
  end
`endif

  always_comb begin
    status_s = 32'h0000_0000;
    status_s[STAT_FULL]               = fifo_full_s;
    status_s[STAT_EMPTY]              = fifo_empty_s;
    status_s[STAT_OVF]                = ovf_r;
    status_s[STAT_CNT_HI:STAT_CNT_LO] = 5'(fifo_count_s);
  end

  // Combinational load path, no wait states.
  always_comb begin
    case (region_s)
      REG_RAM:        readdata = ram_r[addr[AW+1:2]];
      REG_OUT_DATA:   readdata = 32'h0000_0000;
      REG_OUT_STATUS: readdata = status_s;
`ifdef DBUS_TIMER_EN
      REG_TIMER:      readdata = timer_r;
`endif
      default:        readdata = 32'h0000_0000;
    endcase
  end

  assign out_valid = !fifo_empty_s;
  assign out_data  = fifo_head_s;

endmodule
